// File: rtl/alu_coproc_if.sv
// alu_coproc_if: operand/result bus between the FU stage and the ALU coprocessor.
//   OP1, OP2    : operands from the FU operand registers
//   ALUOP       : opcode, qualified by the OP2 strobe
//   CSR_ALU_IN  : [0] protect result, [1] OP1 strobe, [2] OP2 strobe
//   OP3         : result register
//   CSR_ALU_OUT : [0] OP1 ready, [1] OP2 ready, [2] result valid
// master = FU side, slave = coprocessor side.
interface alu_coproc_if #(
  parameter int DBITS     = 32,
  parameter int ALUOPBITS = 4
);
  logic [DBITS-1:0]     OP1;
  logic [DBITS-1:0]     OP2;
  logic [ALUOPBITS-1:0] ALUOP;
  logic [2:0]           CSR_ALU_IN;
  logic [DBITS-1:0]     OP3;
  logic [2:0]           CSR_ALU_OUT;

  modport master (
    output OP1, OP2, ALUOP, CSR_ALU_IN,
    input  OP3, CSR_ALU_OUT
  );

  modport slave (
    input  OP1, OP2, ALUOP, CSR_ALU_IN,
    output OP3, CSR_ALU_OUT
  );
endinterface

// File: rtl/alu_coproc.sv
// alu_coproc: multi-cycle ALU coprocessor behind a three-bit CSR handshake.
//   clk   : single clock, rising edge
//   reset : asynchronous, active-low
//   bus   : alu_coproc_if.slave (operands, opcode, strobes, result, status)
// Logic/arith/compare ops finish in one busy cycle, shifts move one bit per
// cycle, and the optional multiplier is a 32-step shift-add.
// Optional feature macro: ALU_MUL_EN (opcode A = iterative multiply; when
// undefined, opcode A behaves as a reserved opcode).
module alu_coproc #(
  parameter int DBITS     = 32,
  parameter int ALUOPBITS = 4
) (
  input  logic        clk,
  input  logic        reset,
  alu_coproc_if.slave bus
);

  localparam int SHW = $clog2(DBITS);
`ifdef ALU_MUL_EN
  // Must be able to hold DBITS iterations for the multiply.
  localparam int CNT_W = SHW + 1;
`else
  localparam int CNT_W = SHW;
`endif

  localparam logic [ALUOPBITS-1:0] OP_ADD  = ALUOPBITS'(0);
  localparam logic [ALUOPBITS-1:0] OP_SUB  = ALUOPBITS'(1);
  localparam logic [ALUOPBITS-1:0] OP_AND  = ALUOPBITS'(2);
  localparam logic [ALUOPBITS-1:0] OP_OR   = ALUOPBITS'(3);
  localparam logic [ALUOPBITS-1:0] OP_XOR  = ALUOPBITS'(4);
  localparam logic [ALUOPBITS-1:0] OP_SLL  = ALUOPBITS'(5);
  localparam logic [ALUOPBITS-1:0] OP_SRL  = ALUOPBITS'(6);
  localparam logic [ALUOPBITS-1:0] OP_SRA  = ALUOPBITS'(7);
  localparam logic [ALUOPBITS-1:0] OP_SLT  = ALUOPBITS'(8);
  localparam logic [ALUOPBITS-1:0] OP_SLTU = ALUOPBITS'(9);
`ifdef ALU_MUL_EN
  localparam logic [ALUOPBITS-1:0] OP_MUL  = ALUOPBITS'(10);
`endif

  // DONE and HOLD share an output code but must stay distinct states.
  typedef enum logic [2:0] {
    S_OP1  = 3'd0,
    S_OP2  = 3'd1,
    S_BUSY = 3'd2,
    S_DONE = 3'd3,
    S_HOLD = 3'd4
  } state_t;

  state_t               state_q, state_d;
  logic [2:0]           csr_out_q, csr_out_d;
  logic [DBITS-1:0]     op1_q, op1_d;
  logic [DBITS-1:0]     op2_q, op2_d;
  logic [ALUOPBITS-1:0] aluop_q, aluop_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [DBITS-1:0]     op3_q, op3_d;
`ifdef ALU_MUL_EN
  logic [DBITS-1:0]     acc_q, acc_d;
`endif

  function automatic logic [2:0] status_of(input state_t s);
    case (s)
      S_OP1:   status_of = 3'b001;
      S_OP2:   status_of = 3'b010;
      S_BUSY:  status_of = 3'b000;
      default: status_of = 3'b100;
    endcase
  endfunction

  // Number of busy cycles; a zero shift still spends one cycle.
  function automatic logic [CNT_W-1:0] iter_count(input logic [ALUOPBITS-1:0] op,
                                                  input logic [DBITS-1:0]     b);
    iter_count = CNT_W'(1);
    case (op)
      OP_SLL, OP_SRL, OP_SRA: if (b[SHW-1:0] != '0) iter_count = CNT_W'(b[SHW-1:0]);
`ifdef ALU_MUL_EN
      OP_MUL:                 iter_count = CNT_W'(DBITS);
`endif
      default: ;
    endcase
  endfunction

  function automatic logic [DBITS-1:0] simple_result(input logic [ALUOPBITS-1:0] op,
                                                     input logic [DBITS-1:0]     a,
                                                     input logic [DBITS-1:0]     b);
    case (op)
      OP_ADD:  simple_result = a + b;
      OP_SUB:  simple_result = a - b;
      OP_AND:  simple_result = a & b;
      OP_OR:   simple_result = a | b;
      OP_XOR:  simple_result = a ^ b;
      OP_SLT:  simple_result = DBITS'($signed(a) < $signed(b));
      OP_SLTU: simple_result = DBITS'(a < b);
      default: simple_result = '0;
    endcase
  endfunction

  always_comb begin
    state_d = state_q;
    op1_d   = op1_q;
    op2_d   = op2_q;
    aluop_d = aluop_q;
    cnt_d   = cnt_q;
    op3_d   = op3_q;
`ifdef ALU_MUL_EN
    acc_d   = acc_q;
`endif
    case (state_q)
      S_OP1: begin
        if (bus.CSR_ALU_IN[1]) begin
          op1_d   = bus.OP1;
          state_d = S_OP2;
        end
      end
      S_OP2: begin
        if (bus.CSR_ALU_IN[2]) begin
          op2_d   = bus.OP2;
          aluop_d = bus.ALUOP;
          cnt_d   = iter_count(bus.ALUOP, bus.OP2);
`ifdef ALU_MUL_EN
          acc_d   = '0;
`endif
          state_d = S_BUSY;
        end
      end
      S_BUSY: begin
        cnt_d = cnt_q - CNT_W'(1);
        // Shifts and the multiplier advance op1_q in place one step per cycle.
        case (aluop_q)
          OP_SLL: if (op2_q[SHW-1:0] != '0) op1_d = op1_q << 1;
          OP_SRL: if (op2_q[SHW-1:0] != '0) op1_d = op1_q >> 1;
          OP_SRA: if (op2_q[SHW-1:0] != '0) op1_d = {op1_q[DBITS-1], op1_q[DBITS-1:1]};
`ifdef ALU_MUL_EN
          OP_MUL: begin
            if (op2_q[0]) acc_d = acc_q + op1_q;
            op1_d = op1_q << 1;
            op2_d = op2_q >> 1;
          end
`endif
          default: ;
        endcase
        if (cnt_q == CNT_W'(1)) begin
          case (aluop_q)
            OP_SLL, OP_SRL, OP_SRA: op3_d = op1_d;
`ifdef ALU_MUL_EN
            OP_MUL:                 op3_d = acc_d;
`endif
            default:                op3_d = simple_result(aluop_q, op1_q, op2_q);
          endcase
          state_d = S_DONE;
        end
      end
      S_DONE: if (bus.CSR_ALU_IN[0])  state_d = S_HOLD;
      S_HOLD: if (!bus.CSR_ALU_IN[0]) state_d = S_OP1;
      default: state_d = S_OP1;
    endcase
    csr_out_d = status_of(state_d);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_OP1;
      csr_out_q <= 3'b001;
      op1_q     <= '0;
      op2_q     <= '0;
      aluop_q   <= '0;
      cnt_q     <= '0;
      op3_q     <= '0;
`ifdef ALU_MUL_EN
      acc_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      csr_out_q <= csr_out_d;
      op1_q     <= op1_d;
      op2_q     <= op2_d;
      aluop_q   <= aluop_d;
      cnt_q     <= cnt_d;
      op3_q     <= op3_d;
`ifdef ALU_MUL_EN
      acc_q     <= acc_d;
`endif
    end
  end

  assign bus.OP3         = op3_q;
  assign bus.CSR_ALU_OUT = csr_out_q;

endmodule
